// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: memory/instruction widths, NOP encoding and
// the IF/ID boundary bundle handed from fetch to decode.
package pipe_pkg;

    localparam int ADDR_W  = 11;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP           = '0;
    localparam logic [ADDR_W-1:0]  RESET_PC_DFLT = '0;

    typedef struct packed {
        logic [INSTR_W-1:0] ir;
        logic [ADDR_W-1:0]  pc;
        logic               valid;
    } if_id_t;

endpackage

// File: rtl/if_pc_gen.sv
// PC generator: owns fetch_pc, the instruction RAM address/enable and the
// bookkeeping for the word the synchronous RAM is returning this cycle.
module if_pc_gen
    import pipe_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DFLT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] im_addr,
    output logic              im_oen,
    output logic [ADDR_W-1:0] inflight_addr,
    output logic              inflight_v
);

    logic [ADDR_W-1:0] fetch_pc;
    logic              oen_q;

    assign im_oen = oen_q;

    // NOTE: every always_comb output gets a value on every path (default or
    // full if/else chain) so no latch is inferred.
    always_comb begin
        im_addr = fetch_pc;
        if (redirect)
            im_addr = redirect_pc;
        else if (stall)
            im_addr = inflight_addr;  // re-read so Q keeps the held word
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc      <= RESET_PC;
            inflight_addr <= '0;
            inflight_v    <= 1'b0;
            oen_q         <= 1'b1;
        end else begin
            oen_q <= 1'b0;
            if (redirect) begin
                inflight_addr <= redirect_pc;
                inflight_v    <= 1'b1;
                fetch_pc      <= redirect_pc + ADDR_W'(1);
            end else if (!stall) begin
                inflight_addr <= fetch_pc;
                inflight_v    <= ~oen_q;
                // RAM is disabled on the first edge after reset, so RESET_PC
                // must be presented again before the PC may advance.
                if (!oen_q)
                    fetch_pc <= fetch_pc + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: drives the instruction RAM through if_pc_gen and
// registers the returned word into the IF/ID boundary for decode.
module if_stage
    import pipe_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DFLT
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  im_addr,
    output logic               im_oen,
    input  logic [INSTR_W-1:0] im_rdata,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i,
    output logic [INSTR_W-1:0] ir_o,
    output logic [ADDR_W-1:0]  pc_o,
    output logic               valid_o,
    output logic [31:0]        fetch_cnt_o
);

    logic [ADDR_W-1:0] inflight_addr;
    logic              inflight_v;
    if_id_t            if_id_q;
    logic [31:0]       fetch_cnt;

    if_pc_gen #(.RESET_PC(RESET_PC)) u_pc_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall_i),
        .redirect     (redirect_i),
        .redirect_pc  (redirect_pc_i),
        .im_addr      (im_addr),
        .im_oen       (im_oen),
        .inflight_addr(inflight_addr),
        .inflight_v   (inflight_v)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_q   <= '{ir: NOP, pc: '0, valid: 1'b0};
            fetch_cnt <= '0;
        end else begin
            if (redirect_i) begin
                // Squash the word being returned and the one being fetched.
                if_id_q.ir    <= NOP;
                if_id_q.valid <= 1'b0;
            end else if (!stall_i) begin
                if_id_q <= '{ir: im_rdata, pc: inflight_addr, valid: inflight_v};
            end
            if (if_id_q.valid && !stall_i && !redirect_i)
                fetch_cnt <= fetch_cnt + 32'd1;
        end
    end

    assign ir_o        = if_id_q.ir;
    assign pc_o        = if_id_q.pc;
    assign valid_o     = if_id_q.valid;
    assign fetch_cnt_o = fetch_cnt;

endmodule
